// File: rtl/hud_text_formatter_if.sv
// HUD text formatter bus.
// Groups the request side (update, score, lives, frame_sync) and the result side
// (text_buf, busy, done) of hud_text_formatter.
//   master : producer of requests / consumer of the text line (game logic, testbench)
//   slave  : the formatter itself
interface hud_text_formatter_if #(
  parameter int unsigned SCORE_W   = 20,
  parameter int unsigned TEXT_SIZE = 18
);
  logic               update;
  logic [SCORE_W-1:0] score;
  logic [2:0]         lives;
  logic               frame_sync;
  logic [5:0]         text_buf [0:TEXT_SIZE-1];
  logic               busy;
  logic               done;

  modport master (
    output update, score, lives, frame_sync,
    input  text_buf, busy, done
  );

  modport slave (
    input  update, score, lives, frame_sync,
    output text_buf, busy, done
  );
endinterface

// File: rtl/hud_text_formatter.sv
// HUD text formatter.
// Builds the 18-cell line "score nnnnnn hhhhh" as 6-bit font codes for the text-line renderer.
// The score goes through a sequential double-dabble converter, the lives count becomes heart
// glyphs, and the finished line is copied to text_buf only on a frame-sync pulse.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : hud_text_formatter_if.slave
//            update/score/lives : reformat request and its operands
//            frame_sync         : start-of-vblank pulse, gates the commit
//            text_buf           : registered font codes, cell k of the string at index 17-k
//            busy               : high from accepted update until the last commit
//            done               : one-cycle pulse together with a text_buf change
module hud_text_formatter #(
  // The layout is fixed at 18 cells; no other value is legal.
  parameter int unsigned TEXT_SIZE = 18,
  parameter int unsigned SCORE_W   = 20,
  parameter int unsigned MAX_LIVES = 5,
  parameter bit          ZERO_PAD  = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  hud_text_formatter_if.slave bus
);

  localparam logic [5:0] CodeS     = 6'd28;
  localparam logic [5:0] CodeC     = 6'd12;
  localparam logic [5:0] CodeO     = 6'd24;
  localparam logic [5:0] CodeR     = 6'd27;
  localparam logic [5:0] CodeE     = 6'd14;
  localparam logic [5:0] CodeZero  = 6'd0;
  localparam logic [5:0] CodeBlank = 6'd39;
  localparam logic [5:0] CodeHeart = 6'd38;

  // Clamp compare is done at least 20 bits wide so 999999 is always representable.
  localparam int unsigned     CmpW     = (SCORE_W > 20) ? SCORE_W : 20;
  localparam logic [CmpW-1:0] MaxScore = CmpW'(999999);
  localparam logic [2:0]      MaxLives = 3'(MAX_LIVES);

  localparam int unsigned     CntW     = $clog2(SCORE_W + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(SCORE_W - 1);

  typedef enum logic [1:0] {StIdle, StConvert, StWaitSync, StCommit} state_e;

  state_e             state_q;
  logic               busy_q;
  logic               done_q;
  logic [CntW-1:0]    cnt_q;
  logic [SCORE_W-1:0] bin_q;
  logic [23:0]        bcd_q;
  logic [2:0]         lives_q;
  logic               pend_q;
  logic [SCORE_W-1:0] pend_score_q;
  logic [2:0]         pend_lives_q;
  logic [5:0]         text_q [0:TEXT_SIZE-1];

  logic [CmpW-1:0]    score_ext;
  logic [SCORE_W-1:0] score_clamped;
  logic [2:0]         lives_clamped;
  logic [23:0]        bcd_adj;
  logic [5:0]         staged [0:TEXT_SIZE-1];
  logic               lead;

  // Cells that never depend on the operands; digit cells default to '0' (the reset image).
  function automatic logic [5:0] fixed_cell(input int unsigned idx);
    if (idx == 17) return CodeS;
    if (idx == 16) return CodeC;
    if (idx == 15) return CodeO;
    if (idx == 14) return CodeR;
    if (idx == 13) return CodeE;
    if (idx >= 6 && idx <= 11) return CodeZero;
    return CodeBlank;
  endfunction

  always_comb begin
    score_ext     = CmpW'(bus.score);
    score_clamped = (score_ext > MaxScore) ? SCORE_W'(MaxScore) : bus.score;
    lives_clamped = (bus.lives > MaxLives) ? MaxLives : bus.lives;
  end

  // Double-dabble correction step: nibbles >= 5 get +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // Staged line from the converted digits and latched lives.
  always_comb begin
    for (int i = 0; i < int'(TEXT_SIZE); i++) staged[i] = fixed_cell(i);
    lead = !ZERO_PAD;
    // j = 0 is the most significant digit (cell 11); the last digit is never blanked.
    for (int j = 0; j < 6; j++) begin
      if (lead && j < 5 && bcd_q[4*(5-j) +: 4] == 4'd0) begin
        staged[11-j] = CodeBlank;
      end else begin
        staged[11-j] = {2'b00, bcd_q[4*(5-j) +: 4]};
        lead = 1'b0;
      end
    end
    for (int i = 0; i < 5; i++) begin
      staged[4-i] = (3'(i) < lives_q) ? CodeHeart : CodeBlank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      lives_q      <= '0;
      pend_q       <= 1'b0;
      pend_score_q <= '0;
      pend_lives_q <= '0;
      for (int i = 0; i < int'(TEXT_SIZE); i++) text_q[i] <= fixed_cell(i);
    end else begin
      done_q <= 1'b0;

      // Requests arriving while a job is in flight coalesce into one pending slot.
      if (bus.update && state_q != StIdle) begin
        pend_q       <= 1'b1;
        pend_score_q <= score_clamped;
        pend_lives_q <= lives_clamped;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.update) begin
            bin_q   <= score_clamped;
            bcd_q   <= '0;
            lives_q <= lives_clamped;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StConvert;
          end
        end

        StConvert: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) state_q <= StWaitSync;
        end

        StWaitSync: begin
          // text_buf and done move on the same edge that enters StCommit.
          if (bus.frame_sync) begin
            for (int i = 0; i < int'(TEXT_SIZE); i++) text_q[i] <= staged[i];
            done_q  <= 1'b1;
            state_q <= StCommit;
          end
        end

        StCommit: begin
          // An update in this very cycle is the newest request and wins over the slot.
          if (pend_q || bus.update) begin
            bin_q   <= bus.update ? score_clamped : pend_score_q;
            lives_q <= bus.update ? lives_clamped : pend_lives_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= StConvert;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.text_buf = text_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
